// File: rtl/sim_block_device_mem.sv
// ---------------------------------------------------------------------------
// sim_block_device_mem
//
// RAM-backed block device model. It presents the same req/data/resp channel
// set as the DPI-backed block device, so it can stand in for it. Disk
// contents are held in an internal array, so no host file is needed.
// Requests are serialised: one request is in flight at a time.
//
// Ports
//   clock, reset                      rising-edge clock, async active-high reset
//   bdev_req_*   (valid/ready)        request: write flag, first sector, sector
//                                     count, tag
//   bdev_data_*  (valid/ready)        write data beats with tag
//   bdev_resp_*  (valid/ready)        read data beats, or one zero-data ack per
//                                     write, tagged with the owning request
//   bdev_info_nsectors                constant NSECTORS
//   bdev_err                          sticky: out-of-range access or write-data
//                                     tag mismatch; cleared only by reset
//
// Optional feature, macro SIM_BLKDEV_STATS_EN:
//   adds stat_reads / stat_writes (32-bit wrapping completion counters).
// ---------------------------------------------------------------------------
module sim_block_device_mem #(
   parameter int unsigned DATA_BITS    = 64,
   parameter int unsigned TAG_BITS     = 1,
   parameter int unsigned SECTOR_BITS  = 32,
   parameter int unsigned NSECTORS     = 16,
   parameter int unsigned SECTOR_WORDS = 64,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   bdev_req_valid,
   output logic                   bdev_req_ready,
   input  logic                   bdev_req_bits_write,
   input  logic [SECTOR_BITS-1:0] bdev_req_bits_offset,
   input  logic [SECTOR_BITS-1:0] bdev_req_bits_len,
   input  logic [TAG_BITS-1:0]    bdev_req_bits_tag,
   input  logic                   bdev_data_valid,
   output logic                   bdev_data_ready,
   input  logic [DATA_BITS-1:0]   bdev_data_bits_data,
   input  logic [TAG_BITS-1:0]    bdev_data_bits_tag,
   output logic                   bdev_resp_valid,
   input  logic                   bdev_resp_ready,
   output logic [DATA_BITS-1:0]   bdev_resp_bits_data,
   output logic [TAG_BITS-1:0]    bdev_resp_bits_tag,
   output logic [SECTOR_BITS-1:0] bdev_info_nsectors,
   output logic                   bdev_err
`ifdef SIM_BLKDEV_STATS_EN
   ,
   output logic [31:0]            stat_reads,
   output logic [31:0]            stat_writes
`endif
);

   localparam int unsigned LW    = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 0;
   localparam int unsigned WB    = SECTOR_BITS + LW;   // beat count width
   // Word index gets one extra bit: offset*SECTOR_WORDS + beat can exceed WB bits.
   localparam int unsigned AB    = WB + 1;
   localparam int unsigned DEPTH = NSECTORS * SECTOR_WORDS;
   localparam int unsigned MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      WDATA,
      WACK,
      RWAIT,
      RDATA
   } state_t;

   state_t                state_q, state_d;
   logic                  alive_q;
   logic [AB-1:0]         addr_q, addr_d;
   logic [WB-1:0]         rem_q, rem_d;
   logic [31:0]           wait_q, wait_d;
   logic [TAG_BITS-1:0]   tag_q, tag_d;
   logic [DATA_BITS-1:0]  data_q, data_d;
   logic                  err_q, err_d;
   logic                  mem_we;

   logic [DATA_BITS-1:0]  mem [DEPTH];

   logic                  req_fire;
   logic                  range_bad;
   logic [AB-1:0]         start_addr;
   logic [WB-1:0]         total_beats;
   logic [AB-1:0]         nxt_addr;
   logic                  cur_in, nxt_in;
   logic [DATA_BITS-1:0]  cur_word, nxt_word;

   assign bdev_req_ready      = alive_q && (state_q == IDLE);
   assign bdev_data_ready     = (state_q == WDATA);
   assign bdev_resp_valid     = (state_q == WACK) || (state_q == RDATA);
   assign bdev_resp_bits_data = data_q;
   assign bdev_resp_bits_tag  = tag_q;
   assign bdev_info_nsectors  = SECTOR_BITS'(NSECTORS);
   assign bdev_err            = err_q;

   assign req_fire    = bdev_req_valid && bdev_req_ready;
   assign range_bad   = ({1'b0, bdev_req_bits_offset} + {1'b0, bdev_req_bits_len})
                        > (SECTOR_BITS + 1)'(NSECTORS);
   assign start_addr  = AB'(bdev_req_bits_offset) << LW;
   assign total_beats = WB'(bdev_req_bits_len) << LW;

   // Words past the end of the array are dropped on write and read as zero.
   assign nxt_addr = addr_q + AB'(1);
   assign cur_in   = addr_q < AB'(DEPTH);
   assign nxt_in   = nxt_addr < AB'(DEPTH);
   assign cur_word = cur_in ? mem[addr_q[MW-1:0]] : '0;
   assign nxt_word = nxt_in ? mem[nxt_addr[MW-1:0]] : '0;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      wait_d  = wait_q;
      tag_d   = tag_q;
      data_d  = data_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_fire) begin
               tag_d  = bdev_req_bits_tag;
               addr_d = start_addr;
               rem_d  = total_beats;
               data_d = '0;
               if (range_bad) err_d = 1'b1;
               if (bdev_req_bits_write) begin
                  state_d = (total_beats == '0) ? WACK : WDATA;
               end else if (total_beats != '0) begin
                  state_d = RWAIT;
                  wait_d  = 32'(READ_LATENCY - 1);
               end
            end
         end
         WDATA: begin
            if (bdev_data_valid) begin
               mem_we = cur_in;
               if (bdev_data_bits_tag != tag_q) err_d = 1'b1;
               addr_d = nxt_addr;
               rem_d  = rem_q - WB'(1);
               if (rem_q == WB'(1)) begin
                  state_d = WACK;
                  data_d  = '0;
               end
            end
         end
         WACK: begin
            if (bdev_resp_ready) state_d = IDLE;
         end
         RWAIT: begin
            if (wait_q == '0) begin
               state_d = RDATA;
               data_d  = cur_word;
            end else begin
               wait_d = wait_q - 32'd1;
            end
         end
         RDATA: begin
            if (bdev_resp_ready) begin
               if (rem_q == WB'(1)) begin
                  state_d = IDLE;
                  data_d  = '0;
               end else begin
                  addr_d = nxt_addr;
                  rem_d  = rem_q - WB'(1);
                  data_d = nxt_word;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         alive_q <= 1'b0;
         addr_q  <= '0;
         rem_q   <= '0;
         wait_q  <= '0;
         tag_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         wait_q  <= wait_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // Disk contents survive reset.
   always_ff @(posedge clock) begin
      if (mem_we) mem[addr_q[MW-1:0]] <= bdev_data_bits_data;
   end

`ifdef SIM_BLKDEV_STATS_EN
   logic        rd_done, wr_done;
   logic [31:0] stat_reads_q, stat_writes_q;

   assign rd_done = (state_q == RDATA && bdev_resp_ready && rem_q == WB'(1))
                 || (req_fire && !bdev_req_bits_write && bdev_req_bits_len == '0);
   assign wr_done = (state_q == WACK) && bdev_resp_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_reads_q  <= '0;
         stat_writes_q <= '0;
      end else begin
         if (rd_done) stat_reads_q  <= stat_reads_q + 32'd1;
         if (wr_done) stat_writes_q <= stat_writes_q + 32'd1;
      end
   end

   assign stat_reads  = stat_reads_q;
   assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_sim_block_device_mem.sv
// ---------------------------------------------------------------------------
// tb_sim_block_device_mem
//
// Bench for sim_block_device_mem with NSECTORS=4, SECTOR_WORDS=4,
// READ_LATENCY=2. A flat array models the disk; expected response beats are
// queued at request time and checked by an independent monitor.
// ---------------------------------------------------------------------------
module tb_sim_block_device_mem;

   localparam int unsigned NS = 4;
   localparam int unsigned SW = 4;
   localparam int unsigned RL = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        bdev_req_valid;
   logic        bdev_req_ready;
   logic        bdev_req_bits_write;
   logic [31:0] bdev_req_bits_offset;
   logic [31:0] bdev_req_bits_len;
   logic [0:0]  bdev_req_bits_tag;
   logic        bdev_data_valid;
   logic        bdev_data_ready;
   logic [63:0] bdev_data_bits_data;
   logic [0:0]  bdev_data_bits_tag;
   logic        bdev_resp_valid;
   logic        bdev_resp_ready;
   logic [63:0] bdev_resp_bits_data;
   logic [0:0]  bdev_resp_bits_tag;
   logic [31:0] bdev_info_nsectors;
   logic        bdev_err;

   sim_block_device_mem #(
      .DATA_BITS(64),
      .TAG_BITS(1),
      .SECTOR_BITS(32),
      .NSECTORS(NS),
      .SECTOR_WORDS(SW),
      .READ_LATENCY(RL)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bdev_req_valid(bdev_req_valid),
      .bdev_req_ready(bdev_req_ready),
      .bdev_req_bits_write(bdev_req_bits_write),
      .bdev_req_bits_offset(bdev_req_bits_offset),
      .bdev_req_bits_len(bdev_req_bits_len),
      .bdev_req_bits_tag(bdev_req_bits_tag),
      .bdev_data_valid(bdev_data_valid),
      .bdev_data_ready(bdev_data_ready),
      .bdev_data_bits_data(bdev_data_bits_data),
      .bdev_data_bits_tag(bdev_data_bits_tag),
      .bdev_resp_valid(bdev_resp_valid),
      .bdev_resp_ready(bdev_resp_ready),
      .bdev_resp_bits_data(bdev_resp_bits_data),
      .bdev_resp_bits_tag(bdev_resp_bits_tag),
      .bdev_info_nsectors(bdev_info_nsectors),
      .bdev_err(bdev_err)
   );

   always #5 clock = ~clock;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [63:0] model [NS*SW];
   logic [64:0] exp_q [$];
   bit          exp_err;
   int unsigned mon_beats = 0;
   int unsigned dr_cnt    = 0;
   int unsigned rmode     = 0;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Response readiness: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
   initial begin
      int unsigned pidx;
      pidx = 0;
      bdev_resp_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         case (rmode)
            0: bdev_resp_ready = 1'b1;
            1: begin
               bdev_resp_ready = (pidx % 3 == 0);
               pidx++;
            end
            default: bdev_resp_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: a beat offered with ready high is taken at the next rising edge.
   initial begin
      bit          stalled;
      logic [64:0] held, e;
      stalled = 0;
      held    = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            stalled = 0;
         end else begin
            if (bdev_data_ready) dr_cnt++;
            if (stalled) begin
               chk("resp_valid_held", {64'h0, bdev_resp_valid}, 65'h1);
               if (bdev_resp_valid)
                  chk("resp_stable", {bdev_resp_bits_tag, bdev_resp_bits_data}, held);
            end
            if (bdev_resp_valid && bdev_resp_ready) begin
               stalled = 0;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL extra_beat: got %0h expected no beat",
                           {bdev_resp_bits_tag, bdev_resp_bits_data});
               end else begin
                  e = exp_q.pop_front();
                  chk("resp_beat", {bdev_resp_bits_tag, bdev_resp_bits_data}, e);
                  mon_beats++;
               end
            end else if (bdev_resp_valid) begin
               stalled = 1;
               held    = {bdev_resp_bits_tag, bdev_resp_bits_data};
            end else begin
               stalled = 0;
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that ends it.
   task automatic issue_req(input bit wr, input int unsigned off, input int unsigned len,
                            input bit tag, input bit fixed_a, input int unsigned bad_pct);
      bit          r;
      bit          bt;
      int unsigned n;
      logic [63:0] d;
      bdev_req_bits_write  = wr;
      bdev_req_bits_offset = off;
      bdev_req_bits_len    = len;
      bdev_req_bits_tag    = tag;
      bdev_req_valid       = 1'b1;
      n = 0;
      r = 0;
      while (!r && n < 100) begin
         @(negedge clock);
         r = bdev_req_ready;
         @(posedge clock);
         n++;
      end
      #1 bdev_req_valid = 1'b0;
      if (!r) begin
         total++;
         bad++;
         $display("FAIL req_accept: got timeout expected accept");
         return;
      end
      if (off + len > NS) exp_err = 1;
      if (!wr) begin
         for (int unsigned w = off * SW; w < (off + len) * SW; w++)
            exp_q.push_back({tag, (w < NS * SW) ? model[w] : 64'h0});
         if (len > 0) begin
            n = 0;
            while (!bdev_resp_valid && n < 20) begin
               @(posedge clock);
               #1;
               n++;
            end
            chk("read_latency", 65'(n), 65'(RL));
         end
      end else begin
         exp_q.push_back({tag, 64'h0});
         for (int unsigned b = 0; b < len * SW; b++) begin
            d  = fixed_a ? 64'(32'hA0 + b) : {$urandom, $urandom};
            bt = ($urandom_range(0, 99) < bad_pct) ? ~tag : tag;
            if (bt != tag) exp_err = 1;
            if (!fixed_a && $urandom_range(0, 3) == 0) begin
               bdev_data_valid = 1'b0;
               @(posedge clock);
               #1;
            end
            bdev_data_valid     = 1'b1;
            bdev_data_bits_data = d;
            bdev_data_bits_tag  = bt;
            n = 0;
            r = 0;
            while (!r && n < 100) begin
               @(negedge clock);
               r = bdev_data_ready;
               @(posedge clock);
               n++;
            end
            #1;
            if (!r) begin
               total++;
               bad++;
               $display("FAIL data_accept: got timeout expected accept");
               bdev_data_valid = 1'b0;
               return;
            end
            if (off * SW + b < NS * SW) model[off * SW + b] = d;
         end
         bdev_data_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name, output int unsigned cyc);
      cyc = 0;
      while (!(bdev_req_ready && exp_q.size() == 0) && cyc < 300) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      if (cyc >= 300) begin
         total++;
         bad++;
         $display("FAIL %s_idle: got pending=%0d expected pending=0", name, exp_q.size());
         exp_q.delete();
      end
      chk({name, "_err"}, {64'h0, bdev_err}, {64'h0, exp_err});
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_req_ready"},  {64'h0, bdev_req_ready}, 65'h0);
      chk({name, "_data_ready"}, {64'h0, bdev_data_ready}, 65'h0);
      chk({name, "_resp_valid"}, {64'h0, bdev_resp_valid}, 65'h0);
      chk({name, "_resp_data"},  {1'b0, bdev_resp_bits_data}, 65'h0);
      chk({name, "_resp_tag"},   {64'h0, bdev_resp_bits_tag}, 65'h0);
      chk({name, "_err"},        {64'h0, bdev_err}, 65'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got hang expected completion");
      $fatal(1);
   end

   initial begin
      int unsigned cyc, base, dbase;
      bit          wr;
      int unsigned off, len;
      reset                = 1'b1;
      bdev_req_valid       = 1'b0;
      bdev_req_bits_write  = 1'b0;
      bdev_req_bits_offset = '0;
      bdev_req_bits_len    = '0;
      bdev_req_bits_tag    = '0;
      bdev_data_valid      = 1'b0;
      bdev_data_bits_data  = '0;
      bdev_data_bits_tag   = '0;
      exp_err              = 0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_outputs("rst");
      chk("info_nsectors", {33'h0, bdev_info_nsectors}, 65'(NS));
      reset = 1'b0;
      #1 chk("req_ready_before_clk", {64'h0, bdev_req_ready}, 65'h0);
      @(posedge clock);
      #1 chk("req_ready_after_clk", {64'h0, bdev_req_ready}, 65'h1);

      // Fill the whole disk so no word is uninitialised.
      issue_req(1, 0, NS, 0, 0, 0);
      wait_idle("fill", cyc);

      issue_req(1, 1, 1, 1, 1, 0);
      wait_idle("wr_a0", cyc);
      issue_req(0, 1, 1, 0, 0, 0);
      wait_idle("rd_a0", cyc);

      base = mon_beats;
      issue_req(0, 3, 2, 1, 0, 0);
      wait_idle("rd_oor", cyc);
      chk("rd_oor_beats", 65'(mon_beats - base), 65'(2 * SW));

      rmode = 1;
      base  = mon_beats;
      issue_req(0, 0, 2, 0, 0, 0);
      wait_idle("rd_stall", cyc);
      chk("rd_stall_beats", 65'(mon_beats - base), 65'(2 * SW));
      rmode = 0;

      dbase = dr_cnt;
      base  = mon_beats;
      issue_req(1, 2, 0, 1, 0, 0);
      wait_idle("wr_len0", cyc);
      chk("wr_len0_no_dready", 65'(dr_cnt - dbase), 65'h0);
      chk("wr_len0_acks", 65'(mon_beats - base), 65'h1);
      chk("wr_len0_ready_soon", 65'(cyc <= 2), 65'h1);
      base = mon_beats;
      issue_req(0, 2, 0, 0, 0, 0);
      wait_idle("rd_len0", cyc);
      chk("rd_len0_beats", 65'(mon_beats - base), 65'h0);
      chk("rd_len0_ready_soon", 65'(cyc <= 2), 65'h1);

      // Reset in the middle of a read burst: no further beats, outputs cleared.
      base = mon_beats;
      issue_req(0, 1, 1, 1, 0, 0);
      cyc = 0;
      while (mon_beats - base < 2 && cyc < 50) begin
         @(posedge clock);
         cyc++;
      end
      #1 reset = 1'b1;
      exp_q.delete();
      exp_err = 0;
      #1 check_reset_outputs("midrst");
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      #1 chk("midrst_req_ready_before_clk", {64'h0, bdev_req_ready}, 65'h0);
      @(posedge clock);
      #1;
      issue_req(0, 1, 1, 0, 0, 0);
      wait_idle("rd_after_rst", cyc);

      // Randomised traffic, including out-of-range and bad write-data tags.
      for (int i = 0; i < 40; i++) begin
         rmode = ($urandom_range(0, 1) == 0) ? 0 : 2;
         wr    = 1'($urandom_range(0, 1));
         off   = $urandom_range(0, 5);
         len   = $urandom_range(0, 3);
         issue_req(wr, off, len, 1'($urandom_range(0, 1)), 0, 12);
         wait_idle("rand", cyc);
      end

      chk("final_queue_empty", 65'(exp_q.size()), 65'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
